// File: rtl/vc_input_unit_pkg.sv
// Shared definitions for the multi-VC input port: flit type codes, route
// encodings and the per-VC packet state.
package vc_input_unit_pkg;

  // Flit type field codes
  localparam logic [1:0] FLIT_BODY     = 2'b00;
  localparam logic [1:0] FLIT_TAIL     = 2'b01;
  localparam logic [1:0] FLIT_HEADER   = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  // XY route result encodings (rows grow southwards, columns eastwards)
  localparam int unsigned ROUTE_LOCAL = 0;
  localparam int unsigned ROUTE_NORTH = 1;
  localparam int unsigned ROUTE_EAST  = 2;
  localparam int unsigned ROUTE_SOUTH = 3;
  localparam int unsigned ROUTE_WEST  = 4;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'd0,
    VC_WAITING = 2'd1,
    VC_ACTIVE  = 2'd2
  } vc_state_e;

endpackage

// File: rtl/vc_input_unit_vc_lane.sv
// One virtual channel: FWFT circular buffer, packet FSM, header register and
// XY router. All outputs are combinational (suffix _c); the top registers them.
//   wr_en/wr_data   : enqueue request (dropped when full, flagged on overflow_c)
//   grant           : switch dequeues the head flit this cycle
//   chan_alloc      : allocator grant, honoured only in WAITING
//   chan_rdy        : downstream space for this VC
//   head_c          : head flit; req_c: switch request; drop_c: head discarded
//   proto_err_c     : flit-order violation; route_c/route_vld_c: XY route
module vc_input_unit_vc_lane
  import vc_input_unit_pkg::*;
#(
  parameter int unsigned VC_DEPTH_W  = 2,
  parameter int unsigned FLIT_DATA_W = 8,
  parameter int unsigned FLIT_ID_W   = 2,
  parameter int unsigned COL_CORD    = 1,
  parameter int unsigned ROW_CORD    = 1,
  parameter int unsigned COL_ADDR_W  = 2,
  parameter int unsigned ROW_ADDR_W  = 2,
  parameter int unsigned OUT_N_W     = 3,
  localparam int unsigned FLIT_W     = FLIT_ID_W + FLIT_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [FLIT_W-1:0]  wr_data,
  input  logic               grant,
  input  logic               chan_alloc,
  input  logic               chan_rdy,
  output logic [FLIT_W-1:0]  head_c,
  output logic               req_c,
  output logic               drop_c,
  output logic               proto_err_c,
  output logic               overflow_c,
  output logic               route_vld_c,
  output logic [OUT_N_W-1:0] route_c
);

  localparam int unsigned DEPTH  = 1 << VC_DEPTH_W;
  localparam int unsigned ADDR_W = COL_ADDR_W + ROW_ADDR_W;

  logic [FLIT_W-1:0]    mem [DEPTH];
  logic [VC_DEPTH_W:0]  wr_ptr, rd_ptr;
  logic                 full, empty, enq, deq;
  logic [FLIT_ID_W-1:0] head_id;
  logic                 is_hdr, is_last, stray_hdr, capture;
  logic [ADDR_W-1:0]    hdr_addr;
  logic                 hdr_pend;
  logic [COL_ADDR_W-1:0] dst_col;
  logic [ROW_ADDR_W-1:0] dst_row;
  vc_state_e            state, state_nxt;

  // Buffer status is taken from start-of-cycle pointers, so a same-cycle
  // dequeue never makes room for a write to a full VC.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[VC_DEPTH_W] != rd_ptr[VC_DEPTH_W]) &&
                      (wr_ptr[VC_DEPTH_W-1:0] == rd_ptr[VC_DEPTH_W-1:0]);
  assign enq        = wr_en && !full;
  assign overflow_c = wr_en && full;
  assign deq        = grant || drop_c;
  assign head_c     = mem[rd_ptr[VC_DEPTH_W-1:0]];
  assign head_id    = head_c[FLIT_W-1 -: FLIT_ID_W];

  assign is_hdr  = (head_id == FLIT_ID_W'(FLIT_HEADER)) ||
                   (head_id == FLIT_ID_W'(FLIT_HEADTAIL));
  assign is_last = (head_id == FLIT_ID_W'(FLIT_TAIL)) ||
                   (head_id == FLIT_ID_W'(FLIT_HEADTAIL));
  // A HEADER at the head while ACTIVE is an error unless it is the packet's
  // own header that is still waiting to be forwarded.
  assign stray_hdr = (state == VC_ACTIVE) && !empty && !hdr_pend &&
                     (head_id == FLIT_ID_W'(FLIT_HEADER));

  // Buffer pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + (VC_DEPTH_W+1)'(1);
      if (deq) rd_ptr <= rd_ptr + (VC_DEPTH_W+1)'(1);
    end
  end

  // Buffer storage
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[VC_DEPTH_W-1:0]] <= wr_data;
  end

  // Header address and "own header not yet forwarded" flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_addr <= '0;
      hdr_pend <= 1'b0;
    end else if (capture) begin
      hdr_addr <= head_c[ADDR_W-1:0];
      hdr_pend <= 1'b1;
    end else if (grant) begin
      hdr_pend <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= VC_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      VC_IDLE:    if (!empty && is_hdr) state_nxt = VC_WAITING;
      VC_WAITING: if (chan_alloc) state_nxt = VC_ACTIVE;
      VC_ACTIVE: begin
        if (stray_hdr)             state_nxt = VC_WAITING;
        else if (grant && is_last) state_nxt = VC_IDLE;
      end
      default:    state_nxt = VC_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture     = 1'b0;
    drop_c      = 1'b0;
    proto_err_c = 1'b0;
    req_c       = 1'b0;
    case (state)
      VC_IDLE: begin
        if (!empty) begin
          if (is_hdr) begin
            capture = 1'b1;
          end else begin
            drop_c      = 1'b1;
            proto_err_c = 1'b1;
          end
        end
      end
      VC_ACTIVE: begin
        if (stray_hdr) begin
          capture     = 1'b1;
          proto_err_c = 1'b1;
        end else begin
          req_c = !empty && chan_rdy;
        end
      end
      default: ;
    endcase
  end

  assign route_vld_c = (state == VC_WAITING);

  // XY routing: resolve column first, then row
  assign dst_col = hdr_addr[COL_ADDR_W-1:0];
  assign dst_row = hdr_addr[ADDR_W-1:COL_ADDR_W];

  always_comb begin
    route_c = OUT_N_W'(ROUTE_LOCAL);
    if (dst_col > COL_ADDR_W'(COL_CORD))      route_c = OUT_N_W'(ROUTE_EAST);
    else if (dst_col < COL_ADDR_W'(COL_CORD)) route_c = OUT_N_W'(ROUTE_WEST);
    else if (dst_row > ROW_ADDR_W'(ROW_CORD)) route_c = OUT_N_W'(ROUTE_SOUTH);
    else if (dst_row < ROW_ADDR_W'(ROW_CORD)) route_c = OUT_N_W'(ROUTE_NORTH);
  end

endmodule

// File: rtl/vc_input_unit.sv
// Multi-VC input port: write demux into VC_N lanes, round-robin switch stage
// and registered flit/credit/status outputs.
//   data_i/wr_en_i/wr_vc_i   : incoming flit and its target VC
//   credit_o                 : per-VC pulse for every flit leaving a buffer
//   route_res_o/_vld_o       : per-VC XY route, valid while WAITING
//   chan_alloc_i/chan_rdy_i  : allocator grant / downstream space per VC
//   data_o/data_vld_o/data_vc_o : forwarded flit, valid, source VC
//   overflow_o/proto_err_o   : dropped-write and flit-order error pulses
module vc_input_unit
  import vc_input_unit_pkg::*;
#(
  parameter int unsigned VC_N        = 2,
  parameter int unsigned VC_DEPTH_W  = 2,
  parameter int unsigned FLIT_DATA_W = 8,
  parameter int unsigned FLIT_ID_W   = 2,
  parameter int unsigned COL_CORD    = 1,
  parameter int unsigned ROW_CORD    = 1,
  parameter int unsigned COL_ADDR_W  = 2,
  parameter int unsigned ROW_ADDR_W  = 2,
  parameter int unsigned OUT_N_W     = 3,
  localparam int unsigned VC_ID_W    = (VC_N > 2) ? $clog2(VC_N) : 1,
  localparam int unsigned FLIT_W     = FLIT_ID_W + FLIT_DATA_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FLIT_W-1:0]       data_i,
  input  logic                    wr_en_i,
  input  logic [VC_ID_W-1:0]      wr_vc_i,
  output logic [VC_N-1:0]         credit_o,
  output logic [VC_N*OUT_N_W-1:0] route_res_o,
  output logic [VC_N-1:0]         route_res_vld_o,
  input  logic [VC_N-1:0]         chan_alloc_i,
  input  logic [VC_N-1:0]         chan_rdy_i,
  output logic [FLIT_W-1:0]       data_o,
  output logic                    data_vld_o,
  output logic [VC_ID_W-1:0]      data_vc_o,
  output logic                    overflow_o,
  output logic                    proto_err_o
);

  logic [FLIT_W-1:0]  head [VC_N];
  logic [VC_N-1:0]    wr_sel, req, grant, drop, err, ovf;
  logic [VC_ID_W-1:0] rr_ptr, rr_nxt, gnt_idx, idx;
  logic               gnt_any;

  for (genvar v = 0; v < VC_N; v++) begin : g_lane
    assign wr_sel[v] = wr_en_i && (wr_vc_i == VC_ID_W'(v));

    vc_input_unit_vc_lane #(
      .VC_DEPTH_W (VC_DEPTH_W),
      .FLIT_DATA_W(FLIT_DATA_W),
      .FLIT_ID_W  (FLIT_ID_W),
      .COL_CORD   (COL_CORD),
      .ROW_CORD   (ROW_CORD),
      .COL_ADDR_W (COL_ADDR_W),
      .ROW_ADDR_W (ROW_ADDR_W),
      .OUT_N_W    (OUT_N_W)
    ) u_lane (
      .clk        (clk_i),
      .rst        (rst_i),
      .wr_en      (wr_sel[v]),
      .wr_data    (data_i),
      .grant      (grant[v]),
      .chan_alloc (chan_alloc_i[v]),
      .chan_rdy   (chan_rdy_i[v]),
      .head_c     (head[v]),
      .req_c      (req[v]),
      .drop_c     (drop[v]),
      .proto_err_c(err[v]),
      .overflow_c (ovf[v]),
      .route_vld_c(route_res_vld_o[v]),
      .route_c    (route_res_o[v*OUT_N_W +: OUT_N_W])
    );
  end

  // Round-robin pick: first requester at or after rr_ptr
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < VC_N; i++) begin
      idx = VC_ID_W'((32'(rr_ptr) + i) % VC_N);
      if (!gnt_any && req[idx]) begin
        gnt_any    = 1'b1;
        gnt_idx    = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign rr_nxt = (gnt_idx == VC_ID_W'(VC_N - 1)) ? '0 : gnt_idx + VC_ID_W'(1);

  // Output registers and arbiter pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      data_o      <= '0;
      data_vld_o  <= 1'b0;
      data_vc_o   <= '0;
      credit_o    <= '0;
      overflow_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      data_vld_o  <= gnt_any;
      credit_o    <= grant | drop;
      overflow_o  <= |ovf;
      proto_err_o <= |err;
      if (gnt_any) begin
        data_o    <= head[gnt_idx];
        data_vc_o <= gnt_idx;
        rr_ptr    <= rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit with default parameters (VC_N=2, depth 4,
// node at col 1 / row 1).
module tb_vc_input_unit;
  import vc_input_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] data_in;
  logic       wr_en;
  logic       wr_vc;
  logic [1:0] credit;
  logic [5:0] route_res;
  logic [1:0] route_res_vld;
  logic [1:0] chan_alloc;
  logic [1:0] chan_rdy;
  logic [9:0] data_out;
  logic       data_vld;
  logic       data_vc;
  logic       overflow;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  vc_input_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_i         (data_in),
    .wr_en_i        (wr_en),
    .wr_vc_i        (wr_vc),
    .credit_o       (credit),
    .route_res_o    (route_res),
    .route_res_vld_o(route_res_vld),
    .chan_alloc_i   (chan_alloc),
    .chan_rdy_i     (chan_rdy),
    .data_o         (data_out),
    .data_vld_o     (data_vld),
    .data_vc_o      (data_vc),
    .overflow_o     (overflow),
    .proto_err_o    (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic vc, input logic [9:0] f);
    wr_en   = 1'b1;
    wr_vc   = vc;
    data_in = f;
    step();
  endtask

  function automatic logic [9:0] fl(input logic [1:0] id, input logic [7:0] d);
    return {id, d};
  endfunction

  function automatic logic [9:0] hdr(input logic [1:0] col, input logic [1:0] row);
    return {FLIT_HEADER, 4'b0000, row, col};
  endfunction

  logic [9:0] exp_f [6];

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_vc = 1'b0; data_in = '0;
    chan_alloc = '0; chan_rdy = '0;
    step(); step();
    rst = 1'b0;

    // Reset state; route of address 0 from (1,1) is WEST on both VCs
    check("rst_vld",       32'(data_vld), 32'd0);
    check("rst_data",      32'(data_out), 32'd0);
    check("rst_vc",        32'(data_vc), 32'd0);
    check("rst_credit",    32'(credit), 32'd0);
    check("rst_ovf",       32'(overflow), 32'd0);
    check("rst_perr",      32'(proto_err), 32'd0);
    check("rst_route_vld", 32'(route_res_vld), 32'd0);
    check("rst_route",     32'(route_res), 32'h24);

    // 3-flit packet on VC1 to (2,1): route EAST
    wr(1'b1, hdr(2'd2, 2'd1));
    wr(1'b1, fl(FLIT_BODY, 8'h11));
    check("t1_route_vld", 32'(route_res_vld), 32'b10);
    check("t1_route",     32'(route_res[5:3]), ROUTE_EAST);
    wr(1'b1, fl(FLIT_TAIL, 8'h22));
    wr_en = 1'b0; chan_alloc = 2'b10; chan_rdy = 2'b11;
    step();
    chan_alloc = 2'b00;
    check("t1_active_vld", 32'(route_res_vld), 32'd0);
    check("t1_latency",    32'(data_vld), 32'd0);
    exp_f[0] = hdr(2'd2, 2'd1);
    exp_f[1] = fl(FLIT_BODY, 8'h11);
    exp_f[2] = fl(FLIT_TAIL, 8'h22);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_vld",    32'(data_vld), 32'd1);
      check("t1_data",   32'(data_out), 32'(exp_f[i]));
      check("t1_vc",     32'(data_vc), 32'd1);
      check("t1_credit", 32'(credit), 32'b10);
    end
    step();
    check("t1_end_vld",    32'(data_vld), 32'd0);
    check("t1_hold",       32'(data_out), 32'(exp_f[2]));
    check("t1_end_credit", 32'(credit), 32'd0);
    check("t1_idle",       32'(route_res_vld), 32'd0);

    // Two interleaved packets: VC0 to (1,0) NORTH, VC1 to (0,1) WEST
    wr(1'b0, hdr(2'd1, 2'd0));
    wr(1'b1, hdr(2'd0, 2'd1));
    wr(1'b0, fl(FLIT_BODY, 8'h30));
    wr(1'b1, fl(FLIT_BODY, 8'h31));
    wr(1'b0, fl(FLIT_TAIL, 8'h40));
    wr(1'b1, fl(FLIT_TAIL, 8'h41));
    wr_en = 1'b0;
    check("t2_route_vld", 32'(route_res_vld), 32'b11);
    check("t2_route",     32'(route_res), 32'b100_001);
    chan_alloc = 2'b11;
    step();
    chan_alloc = 2'b00;
    exp_f[0] = hdr(2'd1, 2'd0);
    exp_f[1] = hdr(2'd0, 2'd1);
    exp_f[2] = fl(FLIT_BODY, 8'h30);
    exp_f[3] = fl(FLIT_BODY, 8'h31);
    exp_f[4] = fl(FLIT_TAIL, 8'h40);
    exp_f[5] = fl(FLIT_TAIL, 8'h41);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_vld",  32'(data_vld), 32'd1);
      check("t2_vc",   32'(data_vc), 32'(i % 2));
      check("t2_data", 32'(data_out), 32'(exp_f[i]));
    end
    step();
    check("t2_end_vld", 32'(data_vld), 32'd0);

    // Single-flit packet on VC0 to (1,1): route LOCAL
    wr(1'b0, fl(FLIT_HEADTAIL, 8'h05));
    wr_en = 1'b0;
    step();
    check("t3_route_vld", 32'(route_res_vld), 32'b01);
    check("t3_route",     32'(route_res[2:0]), ROUTE_LOCAL);
    chan_alloc = 2'b01;
    step();
    chan_alloc = 2'b00;
    check("t3_latency", 32'(data_vld), 32'd0);
    step();
    check("t3_vld",      32'(data_vld), 32'd1);
    check("t3_data",     32'(data_out), 32'(fl(FLIT_HEADTAIL, 8'h05)));
    check("t3_credit",   32'(credit), 32'b01);
    check("t3_idle",     32'(route_res_vld), 32'd0);
    step();
    check("t3_end_vld",  32'(data_vld), 32'd0);

    // Five writes into depth-4 VC0: the fifth is dropped
    wr(1'b0, fl(FLIT_HEADER, 8'h05));
    wr(1'b0, fl(FLIT_BODY, 8'h01));
    wr(1'b0, fl(FLIT_BODY, 8'h02));
    wr(1'b0, fl(FLIT_BODY, 8'h03));
    check("t4_no_ovf", 32'(overflow), 32'd0);
    wr(1'b0, fl(FLIT_BODY, 8'h04));
    wr_en = 1'b0;
    check("t4_ovf", 32'(overflow), 32'd1);
    chan_alloc = 2'b01;
    step();
    chan_alloc = 2'b00;
    check("t4_ovf_pulse", 32'(overflow), 32'd0);
    exp_f[0] = fl(FLIT_HEADER, 8'h05);
    exp_f[1] = fl(FLIT_BODY, 8'h01);
    exp_f[2] = fl(FLIT_BODY, 8'h02);
    exp_f[3] = fl(FLIT_BODY, 8'h03);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_vld",  32'(data_vld), 32'd1);
      check("t4_data", 32'(data_out), 32'(exp_f[i]));
    end
    step();
    check("t4_retained", 32'(data_vld), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_rst_vld",  32'(data_vld), 32'd0);
    check("t4_rst_data", 32'(data_out), 32'd0);

    // Stray BODY on idle VC1
    wr(1'b1, fl(FLIT_BODY, 8'h77));
    wr_en = 1'b0;
    check("t5_perr_early", 32'(proto_err), 32'd0);
    step();
    check("t5_perr",       32'(proto_err), 32'd1);
    check("t5_credit",     32'(credit), 32'b10);
    check("t5_vld",        32'(data_vld), 32'd0);
    step();
    check("t5_perr_pulse", 32'(proto_err), 32'd0);
    check("t5_credit_end", 32'(credit), 32'd0);
    check("t5_vld_end",    32'(data_vld), 32'd0);

    // chan_rdy[0] low mid-packet, then reset
    chan_rdy = 2'b01;
    wr(1'b0, hdr(2'd2, 2'd2));
    wr(1'b0, fl(FLIT_BODY, 8'h51));
    check("t6_route_vld", 32'(route_res_vld), 32'b01);
    chan_alloc = 2'b01;
    wr(1'b0, fl(FLIT_BODY, 8'h52));
    chan_alloc = 2'b00;
    wr(1'b0, fl(FLIT_TAIL, 8'h53));
    wr_en = 1'b0; chan_rdy = 2'b00;
    check("t6_hdr_vld",  32'(data_vld), 32'd1);
    check("t6_hdr_data", 32'(data_out), 32'(hdr(2'd2, 2'd2)));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_stall", 32'(data_vld), 32'd0);
    end
    rst = 1'b1; chan_rdy = 2'b11;
    step();
    rst = 1'b0;
    check("t6_rst_vld",       32'(data_vld), 32'd0);
    check("t6_rst_data",      32'(data_out), 32'd0);
    check("t6_rst_vc",        32'(data_vc), 32'd0);
    check("t6_rst_credit",    32'(credit), 32'd0);
    check("t6_rst_ovf",       32'(overflow), 32'd0);
    check("t6_rst_perr",      32'(proto_err), 32'd0);
    check("t6_rst_route_vld", 32'(route_res_vld), 32'd0);
    check("t6_rst_route",     32'(route_res), 32'h24);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_flushed_vld",    32'(data_vld), 32'd0);
      check("t6_flushed_credit", 32'(credit), 32'd0);
    end
    // Fresh header on VC1 is processed from IDLE: (1,2) routes SOUTH
    wr(1'b1, hdr(2'd1, 2'd2));
    wr_en = 1'b0;
    step();
    check("t6_new_vld",   32'(route_res_vld), 32'b10);
    check("t6_new_route", 32'(route_res[5:3]), ROUTE_SOUTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
